// File: rtl/hs_fifo.sv
// Multi-entry valid/ready buffer with occupancy flags; optional first-word fall-through via HS_FIFO_FALLTHRU_EN.
// Latency: 1 cycle through an empty buffer, or 0 cycles with HS_FIFO_FALLTHRU_EN defined.
// Backpressure: ready_o drops only when full and ready_i is low, or during flush; ready_i feeds ready_o combinationally.
module hs_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              w_en;
    logic              r_en;

    // Status flags come from registered count only, never from the handshake inputs.
    assign count_o       = count;
    assign full_o        = (count == CNT_W'(DEPTH));
    assign empty_o       = (count == '0);
    assign almost_full_o = (count >= CNT_W'(AFULL_TH));

    // A full buffer still accepts a word when the head is leaving in the same cycle.
    assign ready_o = !flush_i && (!full_o || ready_i);

`ifdef HS_FIFO_FALLTHRU_EN
    logic bypass;

    // An empty buffer hands the incoming word straight through; it is stored only if not taken.
    assign bypass  = empty_o && !flush_i && valid_i && ready_i;
    assign valid_o = !flush_i && (!empty_o || valid_i);
    assign data_o  = empty_o ? data_i : mem[rd_ptr];
    assign w_en    = valid_i && ready_o && !flush_i && !bypass;
    assign r_en    = !empty_o && ready_i && !flush_i;
`else
    assign valid_o = !flush_i && !empty_o;
    assign data_o  = mem[rd_ptr];
    assign w_en    = valid_i && ready_o && !flush_i;
    assign r_en    = valid_o && ready_i && !flush_i;
`endif

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (w_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (r_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({w_en, r_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
